// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_sequencer_if : request, response and ALU-drive bundle                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_binvert;
  logic        alu_carryin;
  logic [1:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_carryout;

  // Requester, response consumer and the combinational ALU.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_carryout,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err,
           alu_a, alu_b, alu_binvert, alu_carryin, alu_operation
  );

  // The sequencer.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_carryout,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err,
           alu_a, alu_b, alu_binvert, alu_carryin, alu_operation
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_sequencer : drives a 32-bit AND/OR/ADD/SUB ALU for AND..SLT and an   |
// | optional 32-step shift-add MUL (enabled by ALU_SEQ_MUL_EN). Rev 1.0      |
// +--------------------------------------------------------------------------+
module alu_sequencer (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] c_op_and = 3'b000;
  localparam logic [2:0] c_op_or  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;
  localparam logic [2:0] c_op_slt = 3'b100;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] c_op_mul = 3'b101;
`endif

  localparam logic [1:0] c_alu_and = 2'b00;
  localparam logic [1:0] c_alu_or  = 2'b10;
  localparam logic [1:0] c_alu_add = 2'b01;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [31:0] r_result;
  logic        r_carry, r_err;

  logic        w_legal;
  logic        w_req_ready, w_rsp_valid;
  logic [31:0] w_alu_a, w_alu_b;
  logic        w_binv, w_cin;
  logic [1:0]  w_alu_op;
  logic [31:0] w_exec_result;
  logic        w_exec_carry;
  logic        w_ovf;

`ifdef ALU_SEQ_MUL_EN
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [31:0] w_acc_next;

  // r_a holds the shifting multiplicand and r_b the shifting multiplier.
  assign w_acc_next = r_b[0] ? bus.alu_result : r_acc;
`endif

  // MUL never reaches EXEC when compiled in, so only AND..SLT are legal here.
  assign w_legal = (r_op <= c_op_slt);

  always_comb begin
    w_next        = r_state;
    w_req_ready   = 1'b0;
    w_rsp_valid   = 1'b0;
    w_alu_a       = 32'd0;
    w_alu_b       = 32'd0;
    w_binv        = 1'b0;
    w_cin         = 1'b0;
    w_alu_op      = c_alu_and;
    w_exec_result = 32'd0;
    w_exec_carry  = 1'b0;
    w_ovf         = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
`ifdef ALU_SEQ_MUL_EN
          w_next = (bus.req_op == c_op_mul) ? MUL : EXEC;
`else
          w_next = EXEC;
`endif
        end
      end
      EXEC: begin
        w_next = DONE;
        if (w_legal) begin
          w_alu_a = r_a;
          w_alu_b = r_b;
        end
        case (r_op)
          c_op_and: begin
            w_exec_result = bus.alu_result;
          end
          c_op_or: begin
            w_alu_op      = c_alu_or;
            w_exec_result = bus.alu_result;
          end
          c_op_add: begin
            w_alu_op      = c_alu_add;
            w_exec_result = bus.alu_result;
            w_exec_carry  = bus.alu_carryout;
          end
          c_op_sub: begin
            w_alu_op      = c_alu_add;
            w_binv        = 1'b1;
            w_cin         = 1'b1;
            w_exec_result = bus.alu_result;
            w_exec_carry  = bus.alu_carryout;
          end
          c_op_slt: begin
            w_alu_op      = c_alu_add;
            w_binv        = 1'b1;
            w_cin         = 1'b1;
            // Sign of a-b corrected for signed overflow.
            w_ovf         = (r_a[31] != r_b[31]) && (bus.alu_result[31] != r_a[31]);
            w_exec_result = {31'd0, bus.alu_result[31] ^ w_ovf};
          end
          default: begin
          end
        endcase
      end
      MUL: begin
`ifdef ALU_SEQ_MUL_EN
        w_alu_a  = r_acc;
        w_alu_b  = r_a;
        w_alu_op = c_alu_add;
        if (r_cnt == 5'd31) begin
          w_next = DONE;
        end
`else
        w_next = IDLE;
`endif
      end
      DONE: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc    <= 32'd0;
      r_cnt    <= 5'd0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_op <= bus.req_op;
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
`ifdef ALU_SEQ_MUL_EN
            r_acc <= 32'd0;
            r_cnt <= 5'd0;
`endif
          end
        end
        EXEC: begin
          r_result <= w_exec_result;
          r_carry  <= w_exec_carry;
          r_err    <= ~w_legal;
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result <= w_acc_next;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.rsp_result    = r_result;
  assign bus.rsp_carry     = r_carry;
  assign bus.rsp_err       = r_err;
  assign bus.alu_a         = w_alu_a;
  assign bus.alu_b         = w_alu_b;
  assign bus.alu_binvert   = w_binv;
  assign bus.alu_carryin   = w_cin;
  assign bus.alu_operation = w_alu_op;
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_sequencer : directed table-driven bench with a behavioural ALU     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: Operation 00 AND, 10 OR, 01 ADD; Binvert/Carryin feed ADD.
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb  = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {32'd0, bus.alu_carryin};
    case (bus.alu_operation)
      2'b00:   bus.alu_result = bus.alu_a & alu_bb;
      2'b10:   bus.alu_result = bus.alu_a | alu_bb;
      2'b01:   bus.alu_result = alu_sum[31:0];
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_carryout = alu_sum[32];
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        carry;
    logic        err;
    logic [3:0]  ctrl;   // {alu_operation, alu_binvert, alu_carryin} in the first cycle
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[20];
  int   nvec = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic carry,
                         input logic err, input logic [3:0] ctrl, input int lat);
    vecs[nvec].name  = nm;
    vecs[nvec].op    = op;
    vecs[nvec].a     = a;
    vecs[nvec].b     = b;
    vecs[nvec].res   = res;
    vecs[nvec].carry = carry;
    vecs[nvec].err   = err;
    vecs[nvec].ctrl  = ctrl;
    vecs[nvec].lat   = lat;
    nvec++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one request, measure latency, check the response, optionally hold
  // rsp_ready low for `hold` cycles, then complete the handshake.
  task automatic do_op(input vec_t v, input int hold);
    int n;
    bit got;
    wait_ready();
    chk($sformatf("%s req_ready", v.name), 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      n++;
      if (n == 1) begin
        chk($sformatf("%s alu_ctrl", v.name),
            32'({bus.alu_operation, bus.alu_binvert, bus.alu_carryin}), 32'(v.ctrl));
        chk($sformatf("%s busy", v.name), 32'(bus.req_ready), 32'd0);
      end
      if (bus.rsp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("%s got_rsp", v.name), 32'(got), 32'd1);
    chk($sformatf("%s latency", v.name), 32'(n), 32'(v.lat));
    chk($sformatf("%s result", v.name), bus.rsp_result, v.res);
    chk($sformatf("%s carry", v.name), 32'(bus.rsp_carry), 32'(v.carry));
    chk($sformatf("%s err", v.name), 32'(bus.rsp_err), 32'(v.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s hold valid", v.name), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("%s hold result", v.name), bus.rsp_result, v.res);
      chk($sformatf("%s hold req_ready", v.name), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk($sformatf("%s post valid", v.name), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("%s post req_ready", v.name), 32'(bus.req_ready), 32'd1);
  endtask

  // Start a request, assert rst during cycle k after acceptance, expect a
  // clean IDLE and no response afterwards.
  task automatic reset_mid_op(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int k);
    int seen = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst busy", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst rsp_result", bus.rsp_result, 32'd0);
    chk("midrst alu_op", 32'(bus.alu_operation), 32'd0);
    chk("midrst alu_a", bus.alu_a, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    chk("midrst no_rsp", 32'(seen), 32'd0);
  endtask

  vec_t hv;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset alu_op", 32'(bus.alu_operation), 32'd0);
    chk("reset rsp_result", bus.rsp_result, 32'd0);
    chk("reset rsp_carry", 32'(bus.rsp_carry), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset alu_ctl", 32'({bus.alu_a, bus.alu_b} != 64'd0) | 32'(bus.alu_binvert)
                         | 32'(bus.alu_carryin), 32'd0);
    rst = 1'b0;

    add_vec("AND",      3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b0, 1'b0, 4'b0000, 2);
    add_vec("OR",       3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b1000, 2);
    add_vec("ADD",      3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0100, 2);
    add_vec("ADD_wrap", 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4'b0100, 2);
    add_vec("AND_mix",  3'b000, 32'hF0F0FF00, 32'h3C3C0FF0, 32'h30300F00, 1'b0, 1'b0, 4'b0000, 2);
    add_vec("SUB_5_7",  3'b011, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 4'b0111, 2);
    add_vec("SUB_7_5",  3'b011, 32'd7,        32'd5,        32'h00000002, 1'b1, 1'b0, 4'b0111, 2);
    add_vec("SLT_neg",  3'b100, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4'b0111, 2);
    add_vec("SLT_ovf",  3'b100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 4'b0111, 2);
    add_vec("SLT_3_5",  3'b100, 32'd3,        32'd5,        32'h00000001, 1'b0, 1'b0, 4'b0111, 2);
    add_vec("SLT_5_3",  3'b100, 32'd5,        32'd3,        32'h00000000, 1'b0, 1'b0, 4'b0111, 2);
    add_vec("ILL_111",  3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 4'b0000, 2);
    add_vec("ILL_110",  3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 4'b0000, 2);
`ifdef ALU_SEQ_MUL_EN
    add_vec("MUL_ffff", 3'b101, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0100, 33);
    add_vec("MUL_m1sq", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'b0100, 33);
    add_vec("MUL_3x5",  3'b101, 32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 4'b0100, 33);
`else
    add_vec("MUL_off",  3'b101, 32'h0000FFFF, 32'h00010001, 32'h00000000, 1'b0, 1'b1, 4'b0000, 2);
`endif
    add_vec("ADD_after_err", 3'b010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 4'b0100, 2);

    for (int i = 0; i < nvec; i++) begin
      do_op(vecs[i], 0);
    end

    hv.name = "BP_ADD"; hv.op = 3'b010; hv.a = 32'd3; hv.b = 32'd4; hv.res = 32'd7;
    hv.carry = 1'b0; hv.err = 1'b0; hv.ctrl = 4'b0100; hv.lat = 2;
    do_op(hv, 10);

`ifdef ALU_SEQ_MUL_EN
    reset_mid_op(3'b101, 32'h0000FFFF, 32'h00010001, 15);
`else
    reset_mid_op(3'b010, 32'd9, 32'd9, 1);
`endif

    hv.name = "ADD_1_1"; hv.op = 3'b010; hv.a = 32'd1; hv.b = 32'd1; hv.res = 32'd2;
    hv.carry = 1'b0; hv.err = 1'b0; hv.ctrl = 4'b0100; hv.lat = 2;
    do_op(hv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
